// File: rtl/pipeline_debug_pkg.sv
// Shared debug-UART definitions: command bytes, run-controller state encoding
// and the default HALT instruction word.
package pipeline_debug_pkg;

  localparam logic [7:0]  CMD_RUN   = 8'h63;  // 'c'
  localparam logic [7:0]  CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0]  CMD_DUMP  = 8'h64;  // 'd'
  localparam logic [7:0]  CMD_BREAK = 8'h68;  // 'h'
  localparam logic [7:0]  CMD_BP    = 8'h62;  // 'b'

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DUMP_REQ  = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_HALTED    = 3'd6,
    ST_BP_ARG    = 3'd7
  } run_state_e;

  function automatic logic state_enables_pipe(run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_run_controller_sat_cnt.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipeline_run_controller_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_run_controller.sv
// Debug-UART driven run/step/halt sequencer producing the pipeline-wide enable.
// Optional breakpoint support: define PIPELINE_CTRL_BREAKPOINT_EN.
module pipeline_run_controller
  import pipeline_debug_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rx_empty,
  input  logic [7:0]       rx_data,
  output logic             rd_uart,
  input  logic [31:0]      instruction,
  input  logic [7:0]       pc,
  output logic             pipe_enable,
  output logic             dump_start,
  input  logic             dump_done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_dbg
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  run_state_e state, state_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       ret_halted, ret_nxt;  // dump return target: 0=IDLE, 1=HALTED
  logic       pop;
  logic       halt_seen;
  logic       bp_hit;

  assign halt_seen = (instruction == HALT_WORD);

`ifdef PIPELINE_CTRL_BREAKPOINT_EN
  logic       bp_valid, bp_valid_nxt;
  logic [7:0] bp_addr, bp_addr_nxt;
  logic       bp_skip, bp_skip_nxt;  // suppresses re-hit until one RUN edge has advanced

  assign bp_hit = (state == ST_RUN) && bp_valid && !bp_skip && (pc == bp_addr) && !halt_seen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bp_valid <= 1'b0;
      bp_addr  <= '0;
      bp_skip  <= 1'b0;
    end else begin
      bp_valid <= bp_valid_nxt;
      bp_addr  <= bp_addr_nxt;
      bp_skip  <= bp_skip_nxt;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      ret_halted <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= drain_nxt;
      ret_halted <= ret_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    ret_nxt   = ret_halted;
    pop       = 1'b0;
`ifdef PIPELINE_CTRL_BREAKPOINT_EN
    bp_valid_nxt = bp_valid;
    bp_addr_nxt  = bp_addr;
    bp_skip_nxt  = bp_skip;
    if (bp_hit)
      bp_skip_nxt = 1'b1;
    else if (state == ST_RUN)
      bp_skip_nxt = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rx_empty) begin
          pop = 1'b1;
          case (rx_data)
            CMD_RUN:  state_nxt = ST_RUN;
            CMD_STEP: state_nxt = ST_STEP;
            CMD_DUMP: begin
              state_nxt = ST_DUMP_REQ;
              ret_nxt   = 1'b0;
            end
`ifdef PIPELINE_CTRL_BREAKPOINT_EN
            CMD_BP:   state_nxt = ST_BP_ARG;
`endif
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        // HALT at IF outranks breakpoints and queued commands; the FIFO is left alone
        if (halt_seen) begin
          drain_nxt = DRAIN_INIT;
          state_nxt = ST_DRAIN;
        end else if (bp_hit) begin
          state_nxt = ST_DUMP_REQ;
          ret_nxt   = 1'b0;
        end else if (!rx_empty) begin
          pop = 1'b1;
          if (rx_data == CMD_BREAK) begin
            state_nxt = ST_DUMP_REQ;
            ret_nxt   = 1'b0;
          end
        end
      end
      ST_STEP: begin
        state_nxt = ST_DUMP_REQ;
        ret_nxt   = 1'b0;
      end
      ST_DRAIN: begin
        drain_nxt = drain_cnt - 4'd1;
        if (drain_cnt == 4'd1) begin
          state_nxt = ST_DUMP_REQ;
          ret_nxt   = 1'b1;
        end
      end
      ST_DUMP_REQ:  state_nxt = ST_DUMP_WAIT;
      ST_DUMP_WAIT: begin
        if (dump_done)
          state_nxt = ret_halted ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        if (!rx_empty) begin
          pop = 1'b1;
          if (rx_data == CMD_DUMP) begin
            state_nxt = ST_DUMP_REQ;
            ret_nxt   = 1'b1;
          end
        end
      end
      ST_BP_ARG: begin
`ifdef PIPELINE_CTRL_BREAKPOINT_EN
        if (!rx_empty) begin
          pop          = 1'b1;
          bp_addr_nxt  = rx_data;
          bp_valid_nxt = 1'b1;
          state_nxt    = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // rd_uart is the only decode off the inputs; gated so reset forces it low too
  assign rd_uart     = pop & reset_n;
  assign pipe_enable = state_enables_pipe(state) && !bp_hit;
  assign dump_start  = (state == ST_DUMP_REQ);
  assign halted      = (state == ST_HALTED);
  assign state_dbg   = state;

  pipeline_run_controller_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (pipe_enable),
    .count   (cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: per-cycle compare against a
// behavioural model plus literal scenario expectations.
module tb_pipeline_run_controller;

  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam int          DRAIN = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3,
                 M_DREQ = 4, M_DWAIT = 5, M_HALTED = 6;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rd_uart;
  logic [31:0] instruction;
  logic [7:0]  pc;
  logic        pipe_enable, dump_start, dump_done, halted;
  logic [31:0] cycle_count;
  logic [2:0]  state_dbg;

  logic        s_rd_uart, s_pipe_enable, s_dump_start, s_halted;
  logic [2:0]  s_cycle_count;
  logic [2:0]  s_state_dbg;

  always #5 clock = ~clock;

  pipeline_run_controller #(.CNT_W(32), .HALT_WORD(32'hFFFF_FFFF), .DRAIN_CYCLES(DRAIN)) dut (
    .clock(clock), .reset_n(reset_n), .rx_empty(rx_empty), .rx_data(rx_data),
    .rd_uart(rd_uart), .instruction(instruction), .pc(pc), .pipe_enable(pipe_enable),
    .dump_start(dump_start), .dump_done(dump_done), .halted(halted),
    .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  // narrow counter copy to exercise saturation
  pipeline_run_controller #(.CNT_W(3), .HALT_WORD(32'hFFFF_FFFF), .DRAIN_CYCLES(DRAIN)) dut_s (
    .clock(clock), .reset_n(reset_n), .rx_empty(rx_empty), .rx_data(rx_data),
    .rd_uart(s_rd_uart), .instruction(instruction), .pc(pc), .pipe_enable(s_pipe_enable),
    .dump_start(s_dump_start), .dump_done(dump_done), .halted(s_halted),
    .cycle_count(s_cycle_count), .state_dbg(s_state_dbg)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  logic [7:0] fifo[$];
  task automatic fifo_drive();
    rx_empty = (fifo.size() == 0);
    rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask
  task automatic push(logic [7:0] b);
    fifo.push_back(b);
    fifo_drive();
  endtask

  // model of the spec's sequencing rules
  int     m_mode = M_IDLE, m_drain = 0, m_ret = 0;
  longint m_cnt = 0;
  int     en_edges = 0, dumps = 0;
  logic   pop_dut = 1'b0;

  always @(negedge clock) begin
    logic        e_en, e_ds, e_h, e_pop;
    logic [2:0]  e_st;
    longint      e_cnt;
    if (!reset_n) begin
      m_mode = M_IDLE; m_drain = 0; m_ret = 0; m_cnt = 0;
    end
    e_en  = reset_n && (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN);
    e_ds  = reset_n && (m_mode == M_DREQ);
    e_h   = reset_n && (m_mode == M_HALTED);
    e_st  = 3'(m_mode);
    e_cnt = m_cnt;
    e_pop = reset_n && !rx_empty &&
            (m_mode == M_IDLE || m_mode == M_HALTED || (m_mode == M_RUN && instruction != HALT));
    chk("pipe_enable", pipe_enable, e_en);
    chk("dump_start",  dump_start,  e_ds);
    chk("halted",      halted,      e_h);
    chk("state_dbg",   state_dbg,   e_st);
    chk("rd_uart",     rd_uart,     e_pop);
    chk("cycle_count", cycle_count, e_cnt);
    chk("sat_count",   s_cycle_count, (e_cnt > 7) ? 7 : e_cnt);
    chk("sat_state",   s_state_dbg, e_st);
    pop_dut = rd_uart;
    if (reset_n) begin
      if (pipe_enable) en_edges++;
      if (dump_start)  dumps++;
      case (m_mode)
        M_IDLE: if (e_pop) begin
          if (rx_data == 8'h63) m_mode = M_RUN;
          else if (rx_data == 8'h73) m_mode = M_STEP;
          else if (rx_data == 8'h64) begin m_mode = M_DREQ; m_ret = 0; end
        end
        M_RUN: begin
          if (instruction == HALT) begin m_mode = M_DRAIN; m_drain = DRAIN; end
          else if (e_pop && rx_data == 8'h68) begin m_mode = M_DREQ; m_ret = 0; end
        end
        M_STEP:  begin m_mode = M_DREQ; m_ret = 0; end
        M_DRAIN: begin
          if (m_drain == 1) begin m_mode = M_DREQ; m_ret = 1; end
          m_drain--;
        end
        M_DREQ:  m_mode = M_DWAIT;
        M_DWAIT: if (dump_done) m_mode = m_ret ? M_HALTED : M_IDLE;
        M_HALTED: if (e_pop && rx_data == 8'h64) begin m_mode = M_DREQ; m_ret = 1; end
        default: m_mode = M_IDLE;
      endcase
      if (e_en) m_cnt++;
    end
  end

  // FIFO consumer side: pop what the DUT strobed on the preceding edge
  always @(posedge clock) begin
    #1;
    if (pop_dut && fifo.size() > 0) void'(fifo.pop_front());
    pop_dut = 1'b0;
    fifo_drive();
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_dump(string name);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clock);
      if (dump_start) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic pulse_done();
    dump_done = 1'b1;
    cyc(1);
    dump_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    instruction = '0;
    fifo.delete();
    fifo_drive();
    cyc(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dumps_base;
    reset_n = 1'b0; dump_done = 1'b0; instruction = '0; pc = '0;
    fifo_drive();
    push(8'h63);

    // reset holds every output low even with a command waiting
    #12;
    chk("rst_rd_uart", rd_uart, 1'b0);
    chk("rst_enable",  pipe_enable, 1'b0);
    chk("rst_state",   state_dbg, 3'd0);
    chk("rst_count",   cycle_count, 32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // continuous run then HALT + drain
    cyc(1);
    chk("run_state", state_dbg, 3'd1);
    chk("run_count0", cycle_count, 32'd0);
    cyc(8);
    chk("run_count8", cycle_count, 32'd8);
    chk("sat_at_max", s_cycle_count, 3'd7);
    en_edges = 0;
    instruction = HALT;
    wait_dump("halt_dump_start");
    chk("halt_en_edges", en_edges, 1 + DRAIN);
    chk("halt_count", cycle_count, 32'd13);
    @(posedge clock); #2;
    instruction = '0;
    push(8'h78);
    cyc(5);
    chk("wait_no_pop", fifo.size(), 1);
    pulse_done();
    chk("halted_set", halted, 1'b1);
    push(8'h63); push(8'h73);
    cyc(4);
    chk("halted_drained", fifo.size(), 0);
    chk("halted_no_en", cycle_count, 32'd13);
    push(8'h64);
    wait_dump("halted_dump");
    @(posedge clock); #2;
    pulse_done();
    chk("still_halted", state_dbg, 3'd6);
    chk("dump_total", dumps, 2);

    // unknown bytes then single step
    do_reset();
    push(8'h71); push(8'h62);
    cyc(2);
    chk("unknown_state", state_dbg, 3'd0);
    chk("unknown_popped", fifo.size(), 0);
    en_edges = 0;
    push(8'h73);
    wait_dump("step_dump");
    chk("step_en_edges", en_edges, 1);
    @(posedge clock); #2;
    cyc(20);
    pulse_done();
    chk("step_idle", state_dbg, 3'd0);
    chk("step_count", cycle_count, 32'd1);

    // break from RUN after a discarded byte
    push(8'h63);
    cyc(4);
    push(8'h78); push(8'h68);
    wait_dump("break_dump");
    chk("break_fifo", fifo.size(), 0);
    chk("break_count", cycle_count, 32'd6);
    @(posedge clock); #2;
    pulse_done();
    chk("break_idle", state_dbg, 3'd0);

    // HALT and 'h' in the same cycle: drain wins, byte stays queued
    push(8'h63);
    cyc(3);
    instruction = HALT;
    push(8'h68);
    cyc(1);
    chk("same_cycle_drain", state_dbg, 3'd3);
    chk("same_cycle_nopop", fifo.size(), 1);
    instruction = '0;
    wait_dump("same_cycle_dump");
    @(posedge clock); #2;
    pulse_done();
    chk("same_cycle_halted", halted, 1'b1);
    cyc(2);
    chk("halted_h_popped", fifo.size(), 0);
    chk("halted_h_ignored", state_dbg, 3'd6);

    // reset in the middle of DRAIN
    do_reset();
    push(8'h63);
    cyc(3);
    instruction = HALT;
    cyc(1);
    instruction = '0;
    cyc(1);
    chk("mid_drain", state_dbg, 3'd3);
    dumps_base = dumps;
    reset_n = 1'b0;
    #1;
    chk("async_enable", pipe_enable, 1'b0);
    chk("async_state", state_dbg, 3'd0);
    chk("async_count", cycle_count, 32'd0);
    chk("async_dump", dump_start, 1'b0);
    cyc(6);
    chk("abort_no_dump", dumps, dumps_base);
    reset_n = 1'b1;
    cyc(2);
    chk("post_reset_idle", state_dbg, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
